// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/result handshake bundle for alu_multicycle.
//   Request side : valid_i, ready_o, ALU_Operation_i[3:0], A_i, B_i
//   Result side  : result_valid_o, result_ready_i, result_o, zero_o
//   master modport = datapath issuing operations, slave modport = the ALU.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;

  modport master (
    output valid_i, ALU_Operation_i, A_i, B_i, result_ready_i,
    input  ready_o, result_valid_o, result_o, zero_o
  );

  modport slave (
    input  valid_i, ALU_Operation_i, A_i, B_i, result_ready_i,
    output ready_o, result_valid_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU for the multi-cycle core variant.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_multicycle_if.slave (request + result valid/ready handshakes)
// Logic/add ops finish in one cycle; SLL/SRL shift one bit per cycle.
// Build option: define ALU_MULTICYCLE_FAST_SHIFT_EN to use a barrel shifter
// instead, which removes the SHIFT state, shift register and counter.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  alu_multicycle_if.slave   bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1101;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1001;
  localparam logic [3:0] OP_JALR = 4'b1010;

`ifdef ALU_MULTICYCLE_FAST_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_res;
  logic [SHAMT_W-1:0]    w_k;

  assign w_k   = bus.B_i[SHAMT_W-1:0];
  assign w_sum = bus.A_i + bus.B_i;

  // Single-cycle result for everything issued straight to DONE.
  always_comb begin
    w_res = '0;
    case (bus.ALU_Operation_i)
      OP_ADD, OP_LW, OP_SW: w_res = w_sum;
      OP_SUB:               w_res = bus.A_i - bus.B_i;
      OP_XOR:               w_res = bus.A_i ^ bus.B_i;
      OP_OR, OP_ORI:        w_res = bus.A_i | bus.B_i;
      OP_AND:               w_res = bus.A_i & bus.B_i;
      OP_LUI:               w_res = bus.B_i;
      OP_JALR:              w_res = {w_sum[DATA_WIDTH-1:1], 1'b0};
`ifdef ALU_MULTICYCLE_FAST_SHIFT_EN
      OP_SLL:               w_res = bus.A_i << w_k;
      OP_SRL:               w_res = bus.A_i >> w_k;
`else
      // Only reached with k==0; nonzero amounts go through SHIFT.
      OP_SLL, OP_SRL:       w_res = bus.A_i;
`endif
      default:              w_res = '0;
    endcase
  end

`ifndef ALU_MULTICYCLE_FAST_SHIFT_EN
  logic [DATA_WIDTH-1:0] r_sh;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_dir;     // 1 = SRL, 0 = SLL
  logic [DATA_WIDTH-1:0] w_sh_nxt;
  logic                  w_start_shift;
  logic                  w_last;

  assign w_start_shift = ((bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL))
                         && (w_k != '0);
  assign w_sh_nxt      = r_dir ? (r_sh >> 1) : (r_sh << 1);
  assign w_last        = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (r_state == S_IDLE && bus.valid_i && w_start_shift) begin
      r_sh  <= bus.A_i;
      r_cnt <= w_k;
      r_dir <= (bus.ALU_Operation_i == OP_SRL);
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= r_cnt - SHAMT_W'(1);
    end
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_i) begin
`ifdef ALU_MULTICYCLE_FAST_SHIFT_EN
          w_next = S_DONE;
`else
          w_next = w_start_shift ? S_SHIFT : S_DONE;
`endif
        end
      end
`ifndef ALU_MULTICYCLE_FAST_SHIFT_EN
      S_SHIFT: if (w_last) w_next = S_DONE;
`endif
      S_DONE:  if (bus.result_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs (ready is a pure state decode, no input path)
  always_comb begin
    bus.ready_o = (r_state == S_IDLE);
  end

  // Result registers: written on entry to DONE, held until handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ALU_MULTICYCLE_FAST_SHIFT_EN
          if (bus.valid_i) begin
`else
          if (bus.valid_i && !w_start_shift) begin
`endif
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_valid  <= 1'b1;
          end
        end
`ifndef ALU_MULTICYCLE_FAST_SHIFT_EN
        S_SHIFT: begin
          if (w_last) begin
            r_result <= w_sh_nxt;
            r_zero   <= (w_sh_nxt == '0);
            r_valid  <= 1'b1;
          end
        end
`endif
        S_DONE:  if (bus.result_ready_i) r_valid <= 1'b0;
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign bus.result_o       = r_result;
  assign bus.zero_o         = r_zero;
  assign bus.result_valid_o = r_valid;
endmodule
